// File: rtl/fetch_predict.sv
// Instruction-fetch stage with a BHT of 2-bit saturating counters.
// Ports: clk/reset; stall/flush/redirect control; BHT training from
//   execute; instruction memory request/response; registered IF/ID
//   outputs (instr_valid_out, instr_out, pc_out, branch_predicted_taken_out).
module fetch_predict #(
    parameter int              XLEN        = 64,
    parameter int              ILEN        = 32,
    parameter int              BHT_ENTRIES = 64,
    parameter logic [XLEN-1:0] RESET_PC    = '0,
    parameter logic [ILEN-1:0] INSTR_NOP   = 32'h00000013
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall_in,
    input  logic            flush_in,
    input  logic            branch_mispredicted_in,
    input  logic [XLEN-1:0] branch_pc_in,
    input  logic            bht_update_in,
    input  logic [XLEN-1:0] bht_update_pc_in,
    input  logic            bht_update_taken_in,
    output logic            instr_read_out,
    output logic [XLEN-1:0] instr_address_out,
    input  logic [ILEN-1:0] instr_read_value_in,
    input  logic            instr_ready_in,
    output logic            instr_valid_out,
    output logic [ILEN-1:0] instr_out,
    output logic [XLEN-1:0] pc_out,
    output logic            branch_predicted_taken_out
);

    localparam int            IW   = $clog2(BHT_ENTRIES);
    localparam logic [IW-1:0] LAST = IW'(BHT_ENTRIES - 1);

    typedef enum logic {INIT, RUN} state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   init_idx_q, init_idx_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic            valid_q, valid_d;
    logic [ILEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] pc_out_q, pc_out_d;
    logic            pred_q, pred_d;

    logic [1:0]      bht_q [BHT_ENTRIES];

    logic            run;
    logic [XLEN-1:0] pc;
    logic [IW-1:0]   idx;
    logic [IW-1:0]   uidx;
    logic [1:0]      ucnt;
    logic [1:0]      ucnt_nxt;
    logic [6:0]      opcode;
    logic            is_jal;
    logic            is_br;
    logic [XLEN-1:0] imm_j;
    logic [XLEN-1:0] imm_b;
    logic            pred_taken;
    logic [XLEN-1:0] pred_next;
    logic            unused_ok;

    assign run = (state_q == RUN);

    // Redirects are ignored while the BHT is being initialised.
    assign pc = (run && branch_mispredicted_in) ? branch_pc_in : fetch_pc_q;
    assign instr_address_out = pc;
    assign instr_read_out    = run;

    assign idx    = pc[IW+1:2];
    assign opcode = instr_read_value_in[6:0];
    assign is_jal = (opcode == 7'b1101111);
    assign is_br  = (opcode == 7'b1100011);

    assign imm_j = {{(XLEN-21){instr_read_value_in[31]}},
                    instr_read_value_in[31],
                    instr_read_value_in[19:12],
                    instr_read_value_in[20],
                    instr_read_value_in[30:21],
                    1'b0};

    assign imm_b = {{(XLEN-13){instr_read_value_in[31]}},
                    instr_read_value_in[31],
                    instr_read_value_in[7],
                    instr_read_value_in[30:25],
                    instr_read_value_in[11:8],
                    1'b0};

    always_comb begin
        pred_taken = 1'b0;
        pred_next  = pc + XLEN'(4);
        unique case (1'b1)
            is_jal: begin
                pred_taken = 1'b1;
                pred_next  = pc + imm_j;
            end
            is_br: begin
                pred_taken = bht_q[idx][1];
                pred_next  = bht_q[idx][1] ? pc + imm_b : pc + XLEN'(4);
            end
            default: begin
                pred_taken = 1'b0;
                pred_next  = pc + XLEN'(4);
            end
        endcase
    end

    assign uidx = bht_update_pc_in[IW+1:2];
    assign ucnt = bht_q[uidx];

    always_comb begin
        ucnt_nxt = ucnt;
        if (bht_update_taken_in) begin
            if (ucnt != 2'b11) ucnt_nxt = ucnt + 2'b01;
        end else begin
            if (ucnt != 2'b00) ucnt_nxt = ucnt - 2'b01;
        end
    end

    // Lookup reads the pre-edge counter, so a same-cycle train is not seen.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_q == INIT) begin
                bht_q[init_idx_q] <= 2'b01;
            end else if (bht_update_in) begin
                bht_q[uidx] <= ucnt_nxt;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        init_idx_d = init_idx_q;
        fetch_pc_d = fetch_pc_q;
        valid_d    = valid_q;
        instr_d    = instr_q;
        pc_out_d   = pc_out_q;
        pred_d     = pred_q;
        unique case (state_q)
            INIT: begin
                init_idx_d = init_idx_q + 1'b1;
                if (init_idx_q == LAST) state_d = RUN;
            end
            RUN: begin
                if (stall_in) begin
                    // pc carries any redirect so it survives the stall
                    fetch_pc_d = pc;
                end else if (!instr_ready_in) begin
                    fetch_pc_d = pc;
                    valid_d    = 1'b0;
                    instr_d    = INSTR_NOP;
                    pred_d     = 1'b0;
                    pc_out_d   = pc;
                end else begin
                    fetch_pc_d = pred_next;
                    pc_out_d   = pc;
                    valid_d    = !flush_in;
                    instr_d    = flush_in ? INSTR_NOP : instr_read_value_in;
                    pred_d     = !flush_in && pred_taken;
                end
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= INIT;
            init_idx_q <= '0;
            fetch_pc_q <= RESET_PC;
            valid_q    <= 1'b0;
            instr_q    <= INSTR_NOP;
            pc_out_q   <= '0;
            pred_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_idx_q <= init_idx_d;
            fetch_pc_q <= fetch_pc_d;
            valid_q    <= valid_d;
            instr_q    <= instr_d;
            pc_out_q   <= pc_out_d;
            pred_q     <= pred_d;
        end
    end

    assign instr_valid_out            = valid_q;
    assign instr_out                  = instr_q;
    assign pc_out                     = pc_out_q;
    assign branch_predicted_taken_out = pred_q;

    assign unused_ok = ^{bht_update_pc_in[XLEN-1:IW+2],
                         bht_update_pc_in[1:0]};

endmodule
